// File: rtl/multicore_llsc_arbiter.sv
// rtl/multicore_llsc_arbiter.sv - N-core round-robin front end to L2 with central LL/SC reservations
module multicore_llsc_arbiter #(
    parameter int NUM_CORES     = 4,
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int RES_GRAN_BITS = 5
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_CORES-1:0]             core_req_valid,
    output logic [NUM_CORES-1:0]             core_req_ready,
    input  logic [2*NUM_CORES-1:0]           core_req_op,
    input  logic [ADDR_WIDTH*NUM_CORES-1:0]  core_req_addr,
    input  logic [DATA_WIDTH*NUM_CORES-1:0]  core_req_wdata,
    output logic [NUM_CORES-1:0]             core_resp_valid,
    output logic [DATA_WIDTH-1:0]            core_resp_rdata,
    output logic                             core_resp_sc_ok,
    output logic                             l2_req_valid,
    output logic                             l2_req_wr,
    output logic [ADDR_WIDTH-1:0]            l2_req_addr,
    output logic [DATA_WIDTH-1:0]            l2_req_wdata,
    input  logic                             l2_resp_valid,
    input  logic [DATA_WIDTH-1:0]            l2_resp_rdata,
    output logic [NUM_CORES-1:0]             res_valid
);

    localparam int IDX_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int SUM_W  = IDX_W + 1;
    localparam int GRAN_W = ADDR_WIDTH - RES_GRAN_BITS;

    localparam logic [1:0] OP_LD = 2'b00;
    localparam logic [1:0] OP_ST = 2'b01;
    localparam logic [1:0] OP_LL = 2'b10;
    localparam logic [1:0] OP_SC = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t                  state_q;
    logic [IDX_W-1:0]        rr_q;
    logic [IDX_W-1:0]        win_q;
    logic [1:0]              op_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    l2_req_valid_q;
    logic [NUM_CORES-1:0]    resp_valid_q;
    logic [DATA_WIDTH-1:0]   resp_rdata_q;
    logic                    resp_sc_ok_q;
    logic [NUM_CORES-1:0]    res_valid_q;
    logic [GRAN_W-1:0]       res_gran_q [NUM_CORES];

    logic                    found_d;
    logic [IDX_W-1:0]        win_d;
    logic [IDX_W-1:0]        rr_d;
    logic [SUM_W-1:0]        cand_sum;
    logic [IDX_W-1:0]        cand;
    logic [1:0]              win_op;
    logic [ADDR_WIDTH-1:0]   win_addr;
    logic [DATA_WIDTH-1:0]   win_wdata;
    logic [GRAN_W-1:0]       win_gran;
    logic                    win_match;
    logic                    sc_fail_d;
    logic [NUM_CORES-1:0]    win_oh;
    logic [GRAN_W-1:0]       cur_gran;
    logic                    kill_gran;
    logic                    sc_failed;

    // Round-robin search: first valid core at or after the pointer, wrapping
    always_comb begin
        found_d  = 1'b0;
        win_d    = '0;
        cand_sum = '0;
        cand     = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            cand_sum = {1'b0, rr_q} + SUM_W'(i);
            if (cand_sum >= SUM_W'(NUM_CORES)) begin
                cand_sum = cand_sum - SUM_W'(NUM_CORES);
            end
            cand = cand_sum[IDX_W-1:0];
            if (!found_d && core_req_valid[cand]) begin
                found_d = 1'b1;
                win_d   = cand;
            end
        end
    end

    assign rr_d      = (win_d == IDX_W'(NUM_CORES - 1)) ? '0 : win_d + 1'b1;
    assign win_op    = core_req_op[win_d*2 +: 2];
    assign win_addr  = core_req_addr[win_d*ADDR_WIDTH +: ADDR_WIDTH];
    assign win_wdata = core_req_wdata[win_d*DATA_WIDTH +: DATA_WIDTH];
    assign win_gran  = win_addr[ADDR_WIDTH-1:RES_GRAN_BITS];
    // Reservations cannot change between accept and ISSUE, so the SC verdict is taken at accept
    assign win_match = res_valid_q[win_d] && (res_gran_q[win_d] == win_gran);
    assign sc_fail_d = (win_op == OP_SC) && !win_match;

    assign win_oh    = NUM_CORES'(1) << win_q;
    assign cur_gran  = addr_q[ADDR_WIDTH-1:RES_GRAN_BITS];
    assign kill_gran = (op_q == OP_ST) || ((op_q == OP_SC) && resp_sc_ok_q);
    assign sc_failed = (op_q == OP_SC) && !resp_sc_ok_q;

    // Grant strobe is combinational so a request can be accepted the cycle valid rises
    assign core_req_ready  = (rst_n && (state_q == S_IDLE) && found_d) ? (NUM_CORES'(1) << win_d) : '0;
    assign core_resp_valid = resp_valid_q;
    assign core_resp_rdata = resp_rdata_q;
    assign core_resp_sc_ok = resp_sc_ok_q;
    assign l2_req_valid    = l2_req_valid_q;
    assign l2_req_wr       = l2_req_valid_q && op_q[0];
    assign l2_req_addr     = l2_req_valid_q ? addr_q : '0;
    assign l2_req_wdata    = (l2_req_valid_q && op_q[0]) ? wdata_q : '0;
    assign res_valid       = res_valid_q;

    // Transaction FSM with registered L2/response strobes and reservation bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            rr_q           <= '0;
            win_q          <= '0;
            op_q           <= OP_LD;
            addr_q         <= '0;
            wdata_q        <= '0;
            l2_req_valid_q <= 1'b0;
            resp_valid_q   <= '0;
            resp_rdata_q   <= '0;
            resp_sc_ok_q   <= 1'b0;
            res_valid_q    <= '0;
            for (int c = 0; c < NUM_CORES; c++) begin
                res_gran_q[c] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (found_d) begin
                        win_q          <= win_d;
                        op_q           <= win_op;
                        addr_q         <= win_addr;
                        wdata_q        <= win_wdata;
                        rr_q           <= rr_d;
                        l2_req_valid_q <= !sc_fail_d;
                        state_q        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    l2_req_valid_q <= 1'b0;
                    if (l2_req_valid_q) begin
                        state_q <= S_WAIT;
                    end else begin
                        state_q      <= S_RESP;
                        resp_valid_q <= win_oh;
                        resp_rdata_q <= '0;
                        resp_sc_ok_q <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (l2_resp_valid) begin
                        state_q      <= S_RESP;
                        resp_valid_q <= win_oh;
                        // op bit 0 marks writes (ST/SC), which return no data
                        resp_rdata_q <= op_q[0] ? '0 : l2_resp_rdata;
                        resp_sc_ok_q <= (op_q == OP_SC);
                    end
                end
                S_RESP: begin
                    state_q      <= S_IDLE;
                    resp_valid_q <= '0;
                    resp_rdata_q <= '0;
                    resp_sc_ok_q <= 1'b0;
                    if (kill_gran) begin
                        for (int c = 0; c < NUM_CORES; c++) begin
                            if (res_valid_q[c] && (res_gran_q[c] == cur_gran)) begin
                                res_valid_q[c] <= 1'b0;
                            end
                        end
                    end
                    if (sc_failed) begin
                        res_valid_q[win_q] <= 1'b0;
                    end
                    if (op_q == OP_LL) begin
                        res_valid_q[win_q] <= 1'b1;
                        res_gran_q[win_q]  <= cur_gran;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multicore_llsc_arbiter.sv
// tb/tb_multicore_llsc_arbiter.sv - randomized self-checking bench for multicore_llsc_arbiter
module tb_multicore_llsc_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int GB = 5;

    localparam int LD = 0;
    localparam int ST = 1;
    localparam int LL = 2;
    localparam int SC = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      core_req_valid = '0;
    logic [N-1:0]      core_req_ready;
    logic [2*N-1:0]    core_req_op = '0;
    logic [AW*N-1:0]   core_req_addr = '0;
    logic [DW*N-1:0]   core_req_wdata = '0;
    logic [N-1:0]      core_resp_valid;
    logic [DW-1:0]     core_resp_rdata;
    logic              core_resp_sc_ok;
    logic              l2_req_valid;
    logic              l2_req_wr;
    logic [AW-1:0]     l2_req_addr;
    logic [DW-1:0]     l2_req_wdata;
    logic              l2_resp_valid;
    logic [DW-1:0]     l2_resp_rdata;
    logic [N-1:0]      res_valid;

    multicore_llsc_arbiter #(
        .NUM_CORES(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RES_GRAN_BITS(GB)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
        .core_req_op(core_req_op), .core_req_addr(core_req_addr), .core_req_wdata(core_req_wdata),
        .core_resp_valid(core_resp_valid), .core_resp_rdata(core_resp_rdata),
        .core_resp_sc_ok(core_resp_sc_ok),
        .l2_req_valid(l2_req_valid), .l2_req_wr(l2_req_wr), .l2_req_addr(l2_req_addr),
        .l2_req_wdata(l2_req_wdata), .l2_resp_valid(l2_resp_valid), .l2_resp_rdata(l2_resp_rdata),
        .res_valid(res_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    // L2 memory with a programmable response latency
    int          l2_mem [int];
    int          l2_lat = 2;
    int          l2_wait = -1;
    int          l2_req_cnt = 0;
    int          l2_req_cyc = 0;
    bit          l2_last_wr = 1'b0;
    logic [31:0] l2_last_addr = '0;
    logic [31:0] l2_last_wdata = '0;

    initial begin
        l2_resp_valid = 1'b0;
        l2_resp_rdata = '0;
        forever begin
            @(negedge clk);
            l2_resp_valid = 1'b0;
            l2_resp_rdata = '0;
            if (l2_wait > 0) begin
                l2_wait--;
                if (l2_wait == 0) begin
                    l2_resp_valid = 1'b1;
                    if (l2_last_wr) l2_resp_rdata = $urandom;
                    else l2_resp_rdata = l2_mem.exists(int'(l2_last_addr)) ? l2_mem[int'(l2_last_addr)] : 0;
                    l2_wait = -1;
                end
            end
            if (l2_req_valid === 1'b1) begin
                l2_req_cnt++;
                l2_req_cyc    = cyc;
                l2_last_wr    = l2_req_wr;
                l2_last_addr  = l2_req_addr;
                l2_last_wdata = l2_req_wdata;
                if (l2_req_wr) l2_mem[int'(l2_req_addr)] = l2_req_wdata;
                l2_wait = l2_lat;
            end
        end
    end

    // Reference model: word memory plus one (valid, granule) reservation per core
    int ref_mem [int];
    bit mrv [N];
    int mrg [N];

    function automatic logic [N-1:0] model_res();
        logic [N-1:0] v;
        for (int c = 0; c < N; c++) v[c] = mrv[c];
        return v;
    endfunction

    function automatic void model_txn(input int c, input int op, input int addr, input int wdata,
                                      output int rdata, output bit sc_ok, output bit l2acc);
        int g;
        g = addr >> GB;
        rdata = 0;
        sc_ok = 1'b0;
        l2acc = 1'b1;
        if (op == LD || op == LL) rdata = ref_mem.exists(addr) ? ref_mem[addr] : 0;
        if (op == LL) begin
            mrv[c] = 1'b1;
            mrg[c] = g;
        end
        if (op == SC) begin
            if (mrv[c] && mrg[c] == g) sc_ok = 1'b1;
            else begin
                l2acc = 1'b0;
                mrv[c] = 1'b0;
            end
        end
        if (op == ST || sc_ok) begin
            ref_mem[addr] = wdata;
            for (int k = 0; k < N; k++) if (mrg[k] == g) mrv[k] = 1'b0;
        end
    endfunction

    task automatic set_word(input int addr, input int val);
        l2_mem[addr]  = val;
        ref_mem[addr] = val;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        core_req_valid = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < N; c++) mrv[c] = 1'b0;
    endtask

    // One transaction from a lone requester, checked end to end against the model
    task automatic run_txn(input int c, input int op, input int addr, input int wdata, input int lat,
                           output logic [31:0] got_rdata, output bit got_sc);
        int erd, t_acc, t_exp, cnt0;
        bit esc, eacc, ok;
        logic [N-1:0] eoh;
        eoh = '0;
        eoh[c] = 1'b1;
        got_rdata = '0;
        got_sc = 1'b0;
        l2_lat = lat;
        model_txn(c, op, addr, wdata, erd, esc, eacc);
        @(negedge clk);
        core_req_valid[c] = 1'b1;
        core_req_op[2*c +: 2] = op[1:0];
        core_req_addr[AW*c +: AW] = addr;
        core_req_wdata[DW*c +: DW] = wdata;
        cnt0 = l2_req_cnt;
        #1;
        n_vec++;
        if (core_req_ready !== eoh) begin
            n_err++;
            $display("FAIL ready_immediate core%0d got=%b exp=%b", c, core_req_ready, eoh);
        end
        ok = (core_req_ready === eoh);
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            #1;
            ok = (core_req_ready === eoh);
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL grant_timeout core%0d got=%b exp=%b", c, core_req_ready, eoh);
            core_req_valid[c] = 1'b0;
            return;
        end
        t_acc = cyc;
        @(negedge clk);
        core_req_valid[c] = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 30 && !ok; k++) begin
            if (core_resp_valid !== '0) ok = 1'b1;
            else @(negedge clk);
        end
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL resp_timeout core%0d got=%b exp=%b", c, core_resp_valid, eoh);
            return;
        end
        got_rdata = core_resp_rdata;
        got_sc = core_resp_sc_ok;
        t_exp = eacc ? t_acc + 2 + lat : t_acc + 2;
        if (core_resp_valid !== eoh) begin
            n_err++;
            $display("FAIL resp_onehot core%0d got=%b exp=%b", c, core_resp_valid, eoh);
        end
        n_vec++;
        if (core_resp_rdata !== erd[31:0]) begin
            n_err++;
            $display("FAIL resp_rdata core%0d op%0d got=%0h exp=%0h", c, op, core_resp_rdata, erd);
        end
        n_vec++;
        if (core_resp_sc_ok !== esc) begin
            n_err++;
            $display("FAIL resp_sc_ok core%0d op%0d got=%0d exp=%0d", c, op, core_resp_sc_ok, esc);
        end
        n_vec++;
        if (cyc !== t_exp) begin
            n_err++;
            $display("FAIL resp_latency core%0d op%0d got=T+%0d exp=T+%0d", c, op, cyc - t_acc, t_exp - t_acc);
        end
        n_vec++;
        if (l2_req_cnt !== cnt0 + int'(eacc)) begin
            n_err++;
            $display("FAIL l2_req_count core%0d op%0d got=%0d exp=%0d", c, op, l2_req_cnt - cnt0, eacc);
        end
        if (eacc) begin
            n_vec++;
            if (l2_req_cyc !== t_acc + 1 || l2_last_wr !== op[0] || l2_last_addr !== addr[31:0]) begin
                n_err++;
                $display("FAIL l2_req_fields got=cyc+%0d wr%0d a%0h exp=cyc+1 wr%0d a%0h",
                         l2_req_cyc - t_acc, l2_last_wr, l2_last_addr, op[0], addr);
            end
            if (op[0]) begin
                n_vec++;
                if (l2_last_wdata !== wdata[31:0]) begin
                    n_err++;
                    $display("FAIL l2_wdata got=%0h exp=%0h", l2_last_wdata, wdata);
                end
            end
        end
        @(negedge clk);
        n_vec++;
        if (core_resp_valid !== '0) begin
            n_err++;
            $display("FAIL resp_one_cycle got=%b exp=0", core_resp_valid);
        end
        n_vec++;
        if (res_valid !== model_res()) begin
            n_err++;
            $display("FAIL res_valid after core%0d op%0d got=%b exp=%b", c, op, res_valid, model_res());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        core_req_valid = '0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({core_req_ready, core_resp_valid, core_resp_rdata, core_resp_sc_ok, l2_req_valid,
             l2_req_wr, l2_req_addr, l2_req_wdata, res_valid} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got=%b/%b/%0h/%b/%b/%b exp=all 0", core_req_ready,
                     core_resp_valid, core_resp_rdata, l2_req_valid, l2_req_wr, res_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load_latency();
        logic [31:0] rd;
        bit sc;
        set_word(32'h1000, 7);
        run_txn(0, LD, 32'h1000, 0, 2, rd, sc);
        n_vec++;
        if (rd !== 32'd7) begin
            n_err++;
            $display("FAIL load_value got=%0h exp=7", rd);
        end
    endtask

    task automatic test_rr_order();
        int got [5];
        int exp_order [5];
        int ngr, g;
        bit reraised;
        exp_order = '{0, 1, 2, 3, 0};
        apply_reset();
        @(negedge clk);
        l2_lat = 1;
        for (int c = 0; c < N; c++) begin
            core_req_valid[c] = 1'b1;
            core_req_op[2*c +: 2] = 2'(LD);
            core_req_addr[AW*c +: AW] = 32'h3000 + 4 * c;
        end
        ngr = 0;
        reraised = 1'b0;
        for (int k = 0; k < 80 && ngr < 5; k++) begin
            #1;
            if (core_req_ready !== '0) begin
                g = 0;
                for (int c = 0; c < N; c++) if (core_req_ready[c]) g = c;
                n_vec++;
                if ($countones(core_req_ready) != 1) begin
                    n_err++;
                    $display("FAIL grant_onehot got=%b exp=one bit", core_req_ready);
                end
                got[ngr] = g;
                ngr++;
                @(negedge clk);
                if (g == 0 && !reraised) reraised = 1'b1;
                else core_req_valid[g] = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        core_req_valid = '0;
        n_vec++;
        if (ngr != 5) begin
            n_err++;
            $display("FAIL rr_grant_count got=%0d exp=5", ngr);
        end
        for (int i = 0; i < ngr; i++) begin
            n_vec++;
            if (got[i] != exp_order[i]) begin
                n_err++;
                $display("FAIL rr_order[%0d] got=%0d exp=%0d", i, got[i], exp_order[i]);
            end
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_ll_sc();
        logic [31:0] rd;
        bit sc;
        run_txn(1, LL, 32'h1000, 0, 2, rd, sc);
        run_txn(1, SC, 32'h1000, 5, 2, rd, sc);
        n_vec++;
        if (sc !== 1'b1 || res_valid[1] !== 1'b0 || l2_mem[32'h1000] != 5) begin
            n_err++;
            $display("FAIL ll_sc_pair got=sc%0d res%0d mem%0h exp=sc1 res0 mem5", sc, res_valid[1], l2_mem[32'h1000]);
        end
    endtask

    task automatic test_store_kills();
        logic [31:0] rd;
        bit sc;
        run_txn(0, LL, 32'h1000, 0, 1, rd, sc);
        run_txn(1, LL, 32'h1000, 0, 3, rd, sc);
        n_vec++;
        if (res_valid[1:0] !== 2'b11) begin
            n_err++;
            $display("FAIL two_reservations got=%b exp=11", res_valid[1:0]);
        end
        run_txn(2, ST, 32'h101C, 32'hABCD, 2, rd, sc);
        n_vec++;
        if (res_valid[1:0] !== 2'b00) begin
            n_err++;
            $display("FAIL store_kills_granule got=%b exp=00", res_valid[1:0]);
        end
        run_txn(0, SC, 32'h1000, 9, 2, rd, sc);
        n_vec++;
        if (sc !== 1'b0) begin
            n_err++;
            $display("FAIL killed_sc got=%0d exp=0", sc);
        end
    endtask

    task automatic test_granule_boundary();
        logic [31:0] rd;
        bit sc;
        run_txn(0, LL, 32'h1000, 0, 2, rd, sc);
        run_txn(1, ST, 32'h1020, 32'h55, 1, rd, sc);
        run_txn(0, SC, 32'h1000, 32'h66, 2, rd, sc);
        n_vec++;
        if (sc !== 1'b1) begin
            n_err++;
            $display("FAIL next_granule_sc got=%0d exp=1", sc);
        end
        run_txn(3, SC, 32'h1000, 32'h77, 2, rd, sc);
        n_vec++;
        if (sc !== 1'b0) begin
            n_err++;
            $display("FAIL no_reservation_sc got=%0d exp=0", sc);
        end
    endtask

    task automatic test_random();
        int addrs [6];
        logic [31:0] rd;
        bit sc;
        addrs = '{32'h2000, 32'h2004, 32'h201C, 32'h2020, 32'h2040, 32'h205C};
        for (int i = 0; i < 60; i++) begin
            run_txn($urandom_range(0, N - 1), $urandom_range(0, 3), addrs[$urandom_range(0, 5)],
                    $urandom, $urandom_range(1, 4), rd, sc);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        bit sc;
        bit seen;
        run_txn(2, LL, 32'h1040, 0, 1, rd, sc);
        @(negedge clk);
        l2_lat = 4;
        core_req_valid[1] = 1'b1;
        core_req_op[2 +: 2] = 2'(LD);
        core_req_addr[AW +: AW] = 32'h1000;
        @(negedge clk);
        core_req_valid[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({core_req_ready, core_resp_valid, core_resp_rdata, core_resp_sc_ok, l2_req_valid,
             l2_req_wr, l2_req_addr, l2_req_wdata, res_valid} !== '0) begin
            n_err++;
            $display("FAIL reset_in_wait got=res%b l2v%b exp=all 0", res_valid, l2_req_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < N; c++) mrv[c] = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (core_resp_valid !== '0) seen = 1'b1;
        end
        n_vec++;
        if (seen) begin
            n_err++;
            $display("FAIL late_l2_resp got=resp seen exp=none");
        end
    endtask

    initial begin
        test_reset();
        test_load_latency();
        test_rr_order();
        test_ll_sc();
        test_store_kills();
        test_granule_boundary();
        test_random();
        test_reset_mid();
        test_ll_sc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
